// File: rtl/aes_v3_iter.sv
// aes_v3_iter: AES SubBytes / MixColumns round unit, forward or inverse.
// SubBytes is iterated over SBOXES shared S-box lanes; MixColumns is single-cycle.
//
// state | meaning
// IDLE  | waiting for valid; substitutes chunk 0 or computes MixColumns on start
// SUB   | substituting chunk <count>; valid low aborts back to IDLE
// DONE  | ready pulse; rd already holds the result
module aes_v3_iter #(
    parameter int XLEN   = 32,
    parameter int SBOXES = 1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            valid,
    input  logic            op_sub,
    input  logic            op_enc,
    input  logic            op_rot,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            ready,
    output logic [XLEN-1:0] rd
);

    localparam int N  = XLEN / (8 * SBOXES);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = XLEN / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0] chunk_acc, mix_res, sub_fin;
    logic            last_chunk;
    logic            load_rd;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    // Inverse MixColumn = forward MixColumn after a cheap {04,00,05,00} pre-mix
    function automatic logic [31:0] mix_col(input logic [31:0] w, input logic enc);
        logic [7:0] a0, a1, a2, a3, u, v;
        a0 = w[7:0];
        a1 = w[15:8];
        a2 = w[23:16];
        a3 = w[31:24];
        if (!enc) begin
            u  = xt(xt(a0 ^ a2));
            v  = xt(xt(a1 ^ a3));
            a0 = a0 ^ u;
            a2 = a2 ^ u;
            a1 = a1 ^ v;
            a3 = a3 ^ v;
        end
        return {xt(a3 ^ a0) ^ a0 ^ a1 ^ a2,
                xt(a2 ^ a3) ^ a3 ^ a0 ^ a1,
                xt(a1 ^ a2) ^ a2 ^ a3 ^ a0,
                xt(a0 ^ a1) ^ a1 ^ a2 ^ a3};
    endfunction

    assign last_chunk = (count == CW'(N - 1));
    assign ready      = (state == DONE);

    // Substitute the SBOXES bytes of the chunk selected by the counter
    always_comb begin
        chunk_acc = acc;
        for (int j = 0; j < SBOXES; j++) begin
            chunk_acc[(int'(count) * SBOXES + j) * 8 +: 8] =
                op_enc ? sbox_fwd(rs1[(int'(count) * SBOXES + j) * 8 +: 8])
                       : sbox_inv(rs1[(int'(count) * SBOXES + j) * 8 +: 8]);
        end
    end

    // Per-word MixColumns and the final rotate/key-XOR applied on the rd load
    always_comb begin
        mix_res = '0;
        sub_fin = '0;
        for (int w = 0; w < NW; w++) begin
            mix_res[32*w +: 32] = mix_col(rs1[32*w +: 32], op_enc);
            sub_fin[32*w +: 32] = (op_rot ? {chunk_acc[32*w +: 8], chunk_acc[32*w+8 +: 24]}
                                          : chunk_acc[32*w +: 32]) ^ rs2[32*w +: 32];
        end
    end

    // Next-state, counter and accumulator control
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = acc;
        load_rd   = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (valid) begin
                    if (op_sub) begin
                        acc_nxt = chunk_acc;
                        if (last_chunk) begin
                            state_nxt = DONE;
                            load_rd   = 1'b1;
                        end else begin
                            state_nxt = SUB;
                            count_nxt = count + CW'(1);
                        end
                    end else begin
                        acc_nxt   = mix_res;
                        state_nxt = DONE;
                        load_rd   = 1'b1;
                    end
                end
            end
            SUB: begin
                if (!valid) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else begin
                    acc_nxt = chunk_acc;
                    if (last_chunk) begin
                        state_nxt = DONE;
                        load_rd   = 1'b1;
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // State, counter and accumulator registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            acc   <= acc_nxt;
        end
    end

    // Result register, written only on the transition into DONE
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd <= '0;
        end else if (load_rd) begin
            rd <= op_sub ? sub_fin : mix_res;
        end
    end

endmodule

// File: tb/tb_aes_v3_iter.sv
// tb_aes_v3_iter: directed and randomized checks of aes_v3_iter over every
// legal (XLEN, SBOXES) pair against a table-driven AES reference model.
module tb_aes_v3_iter;

    logic       g_clk;
    logic       g_resetn;
    logic [6:0] valid_a, sub_a, enc_a, rot_a;
    logic [63:0] rs1_a [7];
    logic [63:0] rs2_a [7];
    logic [6:0] ready_a;
    logic [63:0] rd_a [7];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    for (genvar g = 0; g < 7; g++) begin : g_cfg
        localparam int XL = (g < 3) ? 32 : 64;
        localparam int SB = (g < 3) ? (1 << g) : (1 << (g - 3));
        logic [XL-1:0] rs1_w, rs2_w, rd_w;
        assign rs1_w   = rs1_a[g][XL-1:0];
        assign rs2_w   = rs2_a[g][XL-1:0];
        assign rd_a[g] = 64'(rd_w);
        aes_v3_iter #(.XLEN(XL), .SBOXES(SB)) u_dut (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .valid    (valid_a[g]),
            .op_sub   (sub_a[g]),
            .op_enc   (enc_a[g]),
            .op_rot   (rot_a[g]),
            .rs1      (rs1_w),
            .rs2      (rs2_w),
            .ready    (ready_a[g]),
            .rd       (rd_w)
        );
    end

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box built by walking the multiplicative group with generator 3
    task automatic init_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 4; i++) begin
            if (((k >> i) & 1) == 1) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic int xl_of(input int g);
        return (g < 3) ? 32 : 64;
    endfunction

    function automatic int lat_of(input int g, input logic sub);
        int sb;
        sb = (g < 3) ? (1 << g) : (1 << (g - 3));
        return sub ? xl_of(g) / (8 * sb) : 1;
    endfunction

    function automatic logic [63:0] ref_op(input int xl, input logic sub, input logic enc,
                                           input logic rot, input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] r;
        logic [7:0]  c [4];
        logic [7:0]  acc;
        logic [31:0] word;
        int          coef [4];
        r = '0;
        if (enc) coef = '{2, 3, 1, 1};
        else     coef = '{14, 11, 13, 9};
        for (int w = 0; w < xl / 32; w++) begin
            for (int i = 0; i < 4; i++) c[i] = a[32*w + 8*i +: 8];
            word = '0;
            if (sub) begin
                for (int i = 0; i < 4; i++) word[8*i +: 8] = enc ? sbox_t[c[i]] : isbox_t[c[i]];
                if (rot) word = {word[7:0], word[31:8]};
                word = word ^ b[32*w +: 32];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(c[j], coef[(j - i + 4) % 4]);
                    word[8*i +: 8] = acc;
                end
            end
            r[32*w +: 32] = word;
        end
        return r;
    endfunction

    task automatic issue(input int g, input logic sub, input logic enc, input logic rot,
                         input logic [63:0] a, input logic [63:0] b);
        sub_a[g]   = sub;
        enc_a[g]   = enc;
        rot_a[g]   = rot;
        rs1_a[g]   = a;
        rs2_a[g]   = b;
        valid_a[g] = 1'b1;
    endtask

    // Current cycle is cycle 0 of the operation; bounded wait for ready
    task automatic wait_ready(input int g, input int lat, input logic [63:0] exp, input string tag);
        int n;
        n = 0;
        while (!ready_a[g] && n < 40) begin
            @(posedge g_clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_rd"}, rd_a[g], exp);
    endtask

    task automatic single(input int g, input logic sub, input logic enc, input logic rot,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string tag);
        issue(g, sub, enc, rot, a, b);
        wait_ready(g, lat_of(g, sub), exp, tag);
        valid_a[g] = 1'b0;
        @(posedge g_clk);
        #1;
        check({tag, "_pulse"}, 64'(ready_a[g]), 64'd0);
    endtask

    initial begin
        logic        seen;
        logic        s, e, r;
        logic [63:0] a, b, exp;
        int          lat;

        init_tables();
        g_resetn = 1'b0;
        valid_a  = '0;
        sub_a    = '0;
        enc_a    = '0;
        rot_a    = '0;
        for (int g = 0; g < 7; g++) begin
            rs1_a[g] = '0;
            rs2_a[g] = '0;
        end
        repeat (3) @(posedge g_clk);
        #1;
        check("reset_ready_32", 64'(ready_a[0]), 64'd0);
        check("reset_rd_32", rd_a[0], 64'd0);
        check("reset_ready_64", 64'(ready_a[3]), 64'd0);
        check("reset_rd_64", rd_a[3], 64'd0);
        g_resetn = 1'b1;

        single(0, 1, 1, 0, 64'h53, 64'h0, 64'h636363ED, "sub_fwd");
        single(0, 1, 1, 1, 64'h53, 64'h0, 64'hED636363, "sub_rot");
        single(0, 1, 1, 1, 64'h53, 64'hFFFFFFFF, 64'h129C9C9C, "sub_rot_key");
        single(0, 1, 0, 0, 64'h636363ED, 64'h0, 64'h00000053, "sub_inv");

        single(3, 0, 1, 0, 64'h455313DB455313DB, 64'h0, 64'hBCA14D8EBCA14D8E, "mix_fwd");
        single(3, 0, 0, 0, 64'hBCA14D8EBCA14D8E, 64'h0, 64'h455313DB455313DB, "mix_inv");

        // Abort: drop valid in cycle 3 of an 8-cycle SubBytes
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        issue(3, 1, 1, 0, a, b);
        repeat (3) begin
            @(posedge g_clk);
            #1;
        end
        valid_a[3] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge g_clk);
            #1;
            if (ready_a[3]) seen = 1'b1;
        end
        check("abort_noready", 64'(seen), 64'd0);
        check("abort_rd_hold", rd_a[3], 64'h455313DB455313DB);
        single(3, 1, 1, 0, a, b, ref_op(64, 1, 1, 0, a, b), "after_abort");

        // Reset asserted mid-SUB clears outputs at once
        issue(3, 1, 0, 1, a, b);
        repeat (2) begin
            @(posedge g_clk);
            #1;
        end
        g_resetn   = 1'b0;
        valid_a[3] = 1'b0;
        #1;
        check("midreset_ready", 64'(ready_a[3]), 64'd0);
        check("midreset_rd", rd_a[3], 64'd0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge g_clk);
            #1;
            if (ready_a[3]) seen = 1'b1;
        end
        check("postreset_noready", 64'(seen), 64'd0);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        single(3, 1, 0, 1, a, b, ref_op(64, 1, 0, 1, a, b), "after_reset");

        // Back-to-back random sweep, valid held high across operations
        for (int g = 0; g < 7; g++) begin
            s = 1'($urandom);
            e = 1'($urandom);
            r = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            issue(g, s, e, r, a, b);
            exp = ref_op(xl_of(g), s, e, r, a, b);
            lat = lat_of(g, s);
            for (int k = 0; k < 10; k++) begin
                wait_ready(g, lat, exp, $sformatf("sweep_g%0d_k%0d", g, k));
                if (k < 9) begin
                    s = 1'($urandom);
                    e = 1'($urandom);
                    r = 1'($urandom);
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    issue(g, s, e, r, a, b);
                    exp = ref_op(xl_of(g), s, e, r, a, b);
                    lat = lat_of(g, s);
                end else begin
                    valid_a[g] = 1'b0;
                end
                @(posedge g_clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_v3_iter.md
# aes_v3_iter

Parametrised AES round-function unit for the crypto ISE datapath, successor to the fixed 32-bit sub/mix block. It executes SubBytes (with optional byte-rotate and key XOR) or MixColumns, forward or inverse, over an XLEN-wide operand. SubBytes is iterated over SBOXES shared S-box lanes to trade area for latency. It sits behind the core's multi-cycle functional-unit valid/ready port.

## Interface
Parameters:
- XLEN, 32: operand width; legal values 32 or 64.
- SBOXES, 1: parallel S-box lanes; legal values 1, 2, 4 or 8, with SBOXES <= XLEN/8.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- valid  in  1  request; held high until ready or abort.
- op_sub  in  1  1 = SubBytes path, 0 = MixColumns path.
- op_enc  in  1  1 = forward (encrypt), 0 = inverse (decrypt).
- op_rot  in  1  SubBytes only: rotate each 32-bit word right by 8 after substitution.
- rs1  in  XLEN  state operand.
- rs2  in  XLEN  SubBytes key operand, XORed into the result; ignored for MixColumns.
- ready  out  1  one-cycle pulse; rd valid in this cycle.
- rd  out  XLEN  registered result; holds its value between operations.

## Operation
- Byte i is rs1[8i+7:8i]. A 32-bit word is one AES column; byte 0 is row 0.
- SubBytes: t_i = SBox(b_i) when op_enc=1, else InvSBox(b_i). If op_rot=1, each 32-bit word w of t becomes {w[7:0], w[31:8]}. Result = t XOR rs2.
- MixColumns: each 32-bit word is passed through MixColumn (op_enc=1) or InvMixColumn (op_enc=0). GF(2^8) polynomial is 0x11B.
- FSM states: IDLE, SUB, DONE.
  - IDLE, valid=1, op_sub=1: process chunk 0 (bytes 0..SBOXES-1) into an internal accumulator. Set counter to 1. Go to SUB, or go to DONE if N=1.
  - IDLE, valid=1, op_sub=0: compute the full MixColumns result into the accumulator. Go to DONE.
  - SUB: process chunk k = counter; counter increments. After chunk N-1, go to DONE. N = XLEN/(8*SBOXES).
  - DONE: ready=1 and rd = final result (rotate and XOR applied at the rd load). Return to IDLE unconditionally.
- Counter width is clog2(N), minimum 1 bit. It resets to 0 on every entry to IDLE.
- rs1, rs2 and the op_* inputs must be stable while valid=1. The block does not latch them.

## Timing
- Reset values: ready=0, rd=0, state=IDLE, counter=0.
- Latency, counted from the first IDLE cycle with valid=1 (cycle 0) to the ready cycle:
  - SubBytes: N cycles.
  - MixColumns: 1 cycle.
- Examples: XLEN=32/SBOXES=1 gives 4; XLEN=64/SBOXES=8 gives 1; XLEN=64/SBOXES=1 gives 8.
- rd is updated only in the cycle ready is asserted.
- Back-to-back operation: if valid is still high in the IDLE cycle after DONE, a new operation starts. The minimum issue interval is latency + 1.
- Abort: if valid=0 in SUB, go to IDLE next cycle. No ready pulse; rd is unchanged.
- Reset mid-operation: all state and outputs return to reset values asynchronously. No ready pulse after reset is released.
- ready never asserts while in IDLE or SUB.

## Test plan
- Reset: assert g_resetn=0 mid-SUB -> ready=0 and rd=0 immediately; the first op after release completes normally.
- SubBytes, XLEN=32, SBOXES=1, op_enc=1, op_rot=0, rs1=0x00000053, rs2=0 -> ready in cycle 4 with rd=0x636363ED.
  - Same with op_rot=1 -> rd=0xED636363.
  - Same with op_rot=1 and rs2=0xFFFFFFFF -> rd=0x129C9C9C.
- Inverse SubBytes, op_enc=0, rs1=0x636363ED, rs2=0 -> rd=0x00000053.
- MixColumns, XLEN=64, rs1=0x455313DB_455313DB:
  - op_enc=1 -> ready in cycle 1 with rd=0xBCA14D8E_BCA14D8E.
  - op_enc=0 on that result -> rd returns to rs1.
- Abort: XLEN=64, SBOXES=1 SubBytes, drop valid in cycle 3 -> no ready; rd keeps its previous value; the next op has full latency 8.
- Sweep and back-to-back: random ops for every legal (XLEN, SBOXES) pair, valid held high continuously -> rd matches the reference model and ready pulses every latency+1 cycles.
